mux_dir_dato_burst: RTL

Parametrised successor to the RTC address/data bus multiplexer. It runs single or burst register transfers over the shared tri-state bus `dir_dato`, and generates its own address/data phase timing and strobes. It no longer relies on an external phase counter, a data counter and a `sync` pulse. It sits between the PicoBlaze port decoder (command side) and the RTC chip pins. Burst mode moves `NREG` consecutive registers (date, time, timer) in one command.

---
 rtl/mux_dir_dato_burst.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mux_dir_dato_burst.sv
// RTC address/data bus multiplexer with internal phase timing.
// Runs single or NREG-register burst transfers over the shared tri-state bus dir_dato.
module mux_dir_dato_burst #(
  parameter int         DW         = 8,
  parameter int         NREG       = 9,
  parameter int         PHASE_BITS = 5,
  parameter logic [7:0] BASE_ADDR  = 8'h21
) (
  input  logic               reloj,
  input  logic               resetM,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [7:0]         addr,
  input  logic [DW-1:0]      wdata,
  input  logic [NREG*DW-1:0] wr_bus,
  output logic [NREG*DW-1:0] rd_bus,
  output logic [DW-1:0]      rd_data,
  output logic [4:0]         ch_idx,
  output logic               busy,
  output logic               done,
  output logic               ad,
  output logic               cs_n,
  output logic               rd_n,
  output logic               wr_n,
  inout  wire  [DW-1:0]      dir_dato
);

  localparam int T  = 2 ** PHASE_BITS;
  localparam int H  = T / 2;
  localparam int QW = PHASE_BITS - 1;

  localparam logic [PHASE_BITS-1:0] P_LAST   = {PHASE_BITS{1'b1}};
  localparam logic [PHASE_BITS-1:0] P_CAP    = PHASE_BITS'(T - 3);
  localparam logic [QW-1:0]         Q_DRV_LO = QW'(1);
  localparam logic [QW-1:0]         Q_DRV_HI = QW'(H - 2);
  localparam logic [QW-1:0]         Q_STB_LO = QW'(2);
  localparam logic [QW-1:0]         Q_STB_HI = QW'(H - 3);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  state_t                  r_state;
  logic [PHASE_BITS-1:0]   r_phase;
  logic [4:0]              r_ch;
  logic [1:0]              r_mode;
  logic [7:0]              r_addr;
  logic [DW-1:0]           r_wdata;
  logic [NREG*DW-1:0]      r_wrBus;
  logic [NREG*DW-1:0]      r_rdBus;
  logic [DW-1:0]           r_rdData;
  logic [DW-1:0]           r_dout;
  logic                    r_oe;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ad;
  logic                    r_csN;
  logic                    r_rdN;
  logic                    r_wrN;

  state_t                  w_nState;
  logic [PHASE_BITS-1:0]   w_nPhase;
  logic [4:0]              w_nCh;
  logic                    w_load;
  logic [QW-1:0]           w_nq;
  logic                    w_nHalf;
  logic                    w_nXfer;
  logic                    w_wrPhase;
  logic                    w_strobe;
  logic                    w_drive;
  logic                    w_last;
  logic                    w_capture;
  logic [7:0]              w_addr8;
  logic [DW-1:0]           w_addrBus;
  logic [DW-1:0]           w_wrData;

  assign w_last = !r_mode[1] || (r_ch == 5'(NREG - 1));

  always_comb begin
    w_nState = r_state;
    w_nPhase = r_phase;
    w_nCh    = r_ch;
    w_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nState = XFER;
          w_nPhase = '0;
          w_nCh    = '0;
          w_load   = 1'b1;
        end
      end
      XFER: begin
        w_nPhase = r_phase + 1'b1;
        if (r_phase == P_LAST) begin
          if (w_last) begin
            w_nState = FIN;
            w_nCh    = '0;
          end else begin
            w_nCh = r_ch + 5'd1;
          end
        end
      end
      FIN: begin
        w_nState = IDLE;
        w_nPhase = '0;
        w_nCh    = '0;
      end
      default: begin
        w_nState = IDLE;
        w_nPhase = '0;
        w_nCh    = '0;
      end
    endcase
    if (abort) begin
      w_nState = IDLE;
      w_nPhase = '0;
      w_nCh    = '0;
      w_load   = 1'b0;
    end
  end

  // Outputs are decoded from the next phase so the registered strobes line up with p.
  assign w_nq      = w_nPhase[QW-1:0];
  assign w_nHalf   = w_nPhase[PHASE_BITS-1];
  assign w_nXfer   = (w_nState == XFER);
  assign w_wrPhase = !w_nHalf || !r_mode[0];
  assign w_strobe  = w_nXfer && (w_nq >= Q_STB_LO) && (w_nq <= Q_STB_HI);
  assign w_drive   = w_nXfer && w_wrPhase && (w_nq >= Q_DRV_LO) && (w_nq <= Q_DRV_HI);
  assign w_addr8   = r_mode[1] ? (BASE_ADDR + {3'b000, r_ch}) : r_addr;
  assign w_addrBus = DW'(w_addr8);
  assign w_wrData  = r_mode[1] ? r_wrBus[r_ch*DW +: DW] : r_wdata;
  assign w_capture = (r_state == XFER) && (r_phase == P_CAP) && r_mode[0] && !abort;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_ch    <= '0;
    end else begin
      r_state <= w_nState;
      r_phase <= w_nPhase;
      r_ch    <= w_nCh;
    end
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      r_mode   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wrBus  <= '0;
      r_rdBus  <= '0;
      r_rdData <= '0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ad     <= 1'b1;
      r_csN    <= 1'b1;
      r_rdN    <= 1'b1;
      r_wrN    <= 1'b1;
    end else begin
      if (w_load) begin
        r_mode  <= mode;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_wrBus <= wr_bus;
      end
      r_busy <= w_nXfer;
      r_done <= (w_nState == FIN);
      r_ad   <= !(w_nXfer && !w_nHalf);
      r_csN  <= !w_strobe;
      r_wrN  <= !(w_strobe && w_wrPhase);
      r_rdN  <= !(w_strobe && !w_wrPhase);
      r_oe   <= w_drive;
      r_dout <= w_nHalf ? w_wrData : w_addrBus;
      // The RTC still drives the bus on the last strobe cycle of a read, so sample there.
      if (w_capture) begin
        if (r_mode[1]) begin
          r_rdBus[r_ch*DW +: DW] <= dir_dato;
        end else begin
          r_rdData <= dir_dato;
        end
      end
    end
  end

  assign dir_dato = r_oe ? r_dout : {DW{1'bz}};
  assign rd_bus   = r_rdBus;
  assign rd_data  = r_rdData;
  assign ch_idx   = r_ch;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ad       = r_ad;
  assign cs_n     = r_csN;
  assign rd_n     = r_rdN;
  assign wr_n     = r_wrN;

endmodule
